dac_frame_serializer: RTL and testbench

//  Downstream of the triangle-wave note generator: accepts one 12-bit audio sample per valid/ready

---
 rtl/audio_pkg.sv | 7 +
 rtl/dac_sclk_tick.sv | 25 ++
 rtl/dac_frame_serializer.sv | 106 ++++++++++
 tb/tb_dac_frame_serializer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: shared types and frame constants for the DAC serializer.
package audio_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} dac_state_t;
  localparam int FRAME_BITS = 16;
  localparam int SAMPLE_W = 12;
  localparam logic [1:0] PD_NORMAL = 2'b00;
endpackage

// File: rtl/dac_sclk_tick.sv
// dac_sclk_tick: SCLK half-period divider producing toggle, rise and fall strobes.
module dac_sclk_tick #(
  parameter int HALF_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic sclk,
  output logic tick,
  output logic rise,
  output logic fall
);
  localparam int DW = $clog2(HALF_DIV) + 1;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  always_comb begin
    tick = en && (div_cnt_q == DW'(HALF_DIV - 1));
    div_cnt_d = (!en || tick) ? '0 : div_cnt_q + 1'b1;
    rise = tick && !sclk;
    fall = tick && sclk;
  end
  always_ff @(posedge clk) begin
    if (reset) div_cnt_q <= '0;
    else div_cnt_q <= div_cnt_d;
  end
endmodule

// File: rtl/dac_frame_serializer.sv
// dac_frame_serializer: 12-bit sample to 16-bit SPI frame for the Pmod DA2 DAC.
// Define DAC_VOLUME_EN to add a 3-bit volume scaler applied at accept.
module dac_frame_serializer
  import audio_pkg::*;
#(
  parameter int HALF_DIV   = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                sample_valid,
`ifdef DAC_VOLUME_EN
  input  logic [2:0]          volume,
`endif
  output logic                sample_ready,
  output logic                busy,
  output logic                dac_sync_n,
  output logic                dac_sclk,
  output logic                dac_din
);
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  dac_state_t state_q, state_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [4:0] bit_cnt_q, bit_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic sync_n_q, sync_n_d, sclk_q, sclk_d, din_q, din_d;
  logic [SAMPLE_W-1:0] data12;
  logic accept, tick, rise, fall;
`ifdef DAC_VOLUME_EN
  logic [14:0] scaled;
  assign scaled = 15'(sample) * 15'({1'b0, volume} + 4'd1);
  assign data12 = scaled[14:3];
`else
  assign data12 = sample;
`endif
  assign sample_ready = (state_q == IDLE) && !reset;
  assign busy = state_q != IDLE;
  assign accept = sample_valid && sample_ready;
  assign dac_sync_n = sync_n_q;
  assign dac_sclk = sclk_q;
  assign dac_din = din_q;
  dac_sclk_tick #(.HALF_DIV(HALF_DIV)) u_tick (
    .clk(clk), .reset(reset), .en(state_q == SHIFT), .sclk(sclk_q),
    .tick(tick), .rise(rise), .fall(fall)
  );
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    sync_n_d = sync_n_q;
    sclk_d = sclk_q;
    din_d = din_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = SHIFT;
        shreg_d = {2'b00, PD_NORMAL, data12};
        bit_cnt_d = '0;
        sync_n_d = 1'b0;
        sclk_d = 1'b1;
        din_d = shreg_d[FRAME_BITS-1];
      end
      SHIFT: if (fall) begin
        sclk_d = 1'b0;
        bit_cnt_d = (bit_cnt_q == 5'(FRAME_BITS)) ? bit_cnt_q : bit_cnt_q + 5'd1;
      end else if (rise) begin
        sclk_d = 1'b1;
        // the rise after the 16th fall closes the frame instead of shifting
        if (bit_cnt_q == 5'(FRAME_BITS)) begin
          state_d = GAP;
          sync_n_d = 1'b1;
          din_d = 1'b0;
          gap_cnt_d = '0;
        end else begin
          shreg_d = shreg_q << 1;
          din_d = shreg_q[FRAME_BITS-2];
        end
      end
      GAP: begin
        state_d = (gap_cnt_q == GW'(GAP_CYCLES - 1)) ? IDLE : GAP;
        gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      sync_n_q <= 1'b1;
      sclk_q <= 1'b1;
      din_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      sync_n_q <= sync_n_d;
      sclk_q <= sclk_d;
      din_q <= din_d;
    end
  end
endmodule

// File: tb/tb_dac_frame_serializer.sv
// tb_dac_frame_serializer: table-driven frames with a scoreboard of expected SPI words.
module tb_dac_frame_serializer;
  logic clk = 1'b0, reset = 1'b1, sample_valid = 1'b0;
  logic [11:0] sample = '0;
  logic sample_ready, busy, dac_sync_n, dac_sclk, dac_din;
`ifdef DAC_VOLUME_EN
  logic [2:0] volume = 3'd7;
`endif
  dac_frame_serializer dut (
    .clk(clk), .reset(reset), .sample(sample), .sample_valid(sample_valid),
`ifdef DAC_VOLUME_EN
    .volume(volume),
`endif
    .sample_ready(sample_ready), .busy(busy), .dac_sync_n(dac_sync_n),
    .dac_sclk(dac_sclk), .dac_din(dac_din)
  );
  always #5 clk = ~clk;
  int checks = 0, passed = 0;
  int cyc = 0, t0 = -1, nbits = 0, low_cnt = 0;
  logic prev_sclk = 1'b1, prev_sync = 1'b1, aborted = 1'b0;
  logic [15:0] cap = '0;
  logic [15:0] exp_q[$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  // monitor: rebuilds each frame from din at SCLK falls and pops the scoreboard
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (!prev_sync) begin
        aborted = 1'b1;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      t0 = -1;
      nbits = 0;
      low_cnt = 0;
    end else begin
      if (t0 >= 0 && cyc == t0 + 66) check("busy_at_t66", {30'd0, sample_ready, busy}, 32'd1);
      if (t0 >= 0 && cyc == t0 + 67) check("ready_at_t67", {30'd0, sample_ready, busy}, 32'd2);
      if (!dac_sync_n) begin
        low_cnt++;
        if (prev_sclk && !dac_sclk) begin
          cap = {cap[14:0], dac_din};
          nbits++;
        end
      end
    end
    if (!prev_sync && dac_sync_n) begin
      if (!aborted) begin
        check("sync_low_cycles", low_cnt, 64);
        check("frame_bits", nbits, 16);
        if (exp_q.size() != 0) check("frame_data", {16'd0, cap}, {16'd0, exp_q.pop_front()});
        else begin
          checks++;
          $display("FAIL unexpected_frame: got %0h expected none", cap);
        end
      end
      aborted = 1'b0;
      nbits = 0;
      low_cnt = 0;
    end
    if (!reset && sample_valid && sample_ready) t0 = cyc;
    prev_sclk = dac_sclk;
    prev_sync = dac_sync_n;
  end
  task automatic send(input logic [11:0] s, input logic [15:0] exp, input bit hold, output longint acc);
    sample = s;
    sample_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 200 && acc < 0; i++) begin
      @(negedge clk);
      if (sample_ready) begin
        acc = longint'($time);
        exp_q.push_back(exp);
      end
    end
    if (acc < 0) begin
      checks++;
      $display("FAIL accept_timeout: got no accept expected accept of %0h", s);
    end
    @(posedge clk);
    #1;
    if (!hold) sample_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_ready && n < 200);
    if (!sample_ready) begin
      checks++;
      $display("FAIL idle_timeout: got ready=0 expected ready=1");
    end
    @(posedge clk);
    #1;
  endtask
  typedef struct {
    logic [11:0] s;
    logic [15:0] exp;
  } vec_t;
  vec_t v[6];
  longint a1, a2;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    v[0] = '{12'h044, 16'h0044};
    v[1] = '{12'hA5C, 16'h0A5C};
    v[2] = '{12'h123, 16'h0123};
    v[3] = '{12'h800, 16'h0800};
    v[4] = '{12'h001, 16'h0001};
    v[5] = '{12'hFFF, 16'h0FFF};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sync_n", dac_sync_n, 1);
    check("rst_sclk", dac_sclk, 1);
    check("rst_din", dac_din, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", sample_ready, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", sample_ready, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      send(v[i].s, v[i].exp, 1'b0, a1);
      sample = ~v[i].s;
      wait_idle();
    end
    send(12'h000, 16'h0000, 1'b1, a1);
    sample = 12'hFFF;
    send(12'hFFF, 16'h0FFF, 1'b0, a2);
    check("b2b_accept_gap", 32'((a2 - a1) / 10), 67);
    wait_idle();
    send(12'h3C3, 16'h03C3, 1'b0, a1);
    repeat (9) @(posedge clk);
    #1;
    sample = 12'h777;
    sample_valid = 1'b1;
    @(negedge clk);
    check("pulse_ready", sample_ready, 0);
    @(posedge clk);
    #1 sample_valid = 1'b0;
    wait_idle();
    check("pulse_not_queued", exp_q.size(), 0);
    send(12'h5A5, 16'h05A5, 1'b0, a1);
    repeat (19) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_sync_n", dac_sync_n, 1);
    check("abort_sclk", dac_sclk, 1);
    check("abort_busy", busy, 0);
    @(posedge clk);
    #1;
    send(12'h6B6, 16'h06B6, 1'b0, a1);
    wait_idle();
    check("abort_queue_empty", exp_q.size(), 0);
`ifdef DAC_VOLUME_EN
    volume = 3'd3;
    send(12'hFFF, 16'h07FF, 1'b0, a1);
    volume = 3'd0;
    wait_idle();
    volume = 3'd7;
    send(12'hFFF, 16'h0FFF, 1'b0, a1);
    wait_idle();
    volume = 3'd0;
    send(12'hFFF, 16'h01FF, 1'b0, a1);
    volume = 3'd7;
    wait_idle();
`endif
    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
